ap_mem_scheduler: RTL and testbench
===================================

Name: ap_mem_scheduler

Overview:
- Controller that shares the wide AP vector memory (element_width*no_of_units bits per word) between two write requesters and one burst reader.
- Requester A is the matrix-vector unit, which streams one AP vector sequentially from a base address.
- Requester B is the loader/host, which writes single words at random addresses.
- The read sequencer streams one full vector out to the dot-product unit with a registered, 1-cycle-latency output.
- The block sits between the CG datapath and the memory's write_enable/address/input_data/read_address/memory_output pins.

Parameters:
- element_width, 64, bits per element
- no_of_units, 8, elements per memory word
- number_of_equations_per_cluster, 9, vector length N
- mem_depth, 2001, number of memory words; valid addresses are 0..mem_depth-1
- Derived words_per_vector W = ceil(N/no_of_units). With the defaults, W = 2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wa_start  in  1  pulse; begin a vector write at wa_base
- wa_base  in  32  base word address, sampled on wa_start
- wa_valid  in  1  A data valid
- wa_data  in  element_width*no_of_units  A data
- wa_ready  out  1  A word accepted this cycle
- wa_done  out  1  one-cycle pulse after the last A word is accepted
- wb_valid  in  1  B write request
- wb_addr  in  32  B word address
- wb_data  in  element_width*no_of_units  B data
- wb_ready  out  1  B write accepted this cycle
- rd_start  in  1  pulse; begin a vector read at rd_base
- rd_base  in  32  read base, sampled on rd_start
- rd_busy  out  1  read burst in progress
- rd_data_valid  out  1  rd_data holds a valid word
- rd_data  out  element_width*no_of_units  registered read word
- rd_last  out  1  qualifies the final word of a burst
- wr_err  out  1  sticky flag: an out-of-range write was suppressed
- mem_write_enable  out  1  to memory write_enable
- mem_address  out  32  to memory address
- mem_input_data  out  element_width*no_of_units  to memory input_data
- mem_read_address  out  32  to memory read_address
- mem_output  in  element_width*no_of_units  from memory memory_output (combinational read)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Both FSMs go to IDLE; all counters and base registers clear to 0.
  - Every output is 0, including rd_data and wr_err.
  - The round-robin pointer is set to "last grant = B".
  - Bursts in flight are abandoned and are not resumed after reset.
- Write FSM A, states IDLE and ACTIVE:
  - IDLE: on wa_start, capture wa_base, set wcnt=0, go to ACTIVE. wa_ready=0 in IDLE.
  - ACTIVE: each accepted word (wa_valid & wa_ready) writes to wa_base+wcnt, then wcnt increments.
  - On acceptance of word W-1, go to IDLE and pulse wa_done on the next cycle.
  - wa_start while ACTIVE is ignored.
- Arbitration of the write port:
  - Candidates are A (ACTIVE & wa_valid) and B (wb_valid).
  - If only one candidate is present, it is granted.
  - If both are present, the candidate not granted last wins (round-robin); the pointer updates on every grant.
  - wa_ready and wb_ready equal the grant and are combinational from valid and state. At most one is high per cycle.
- Memory drive (combinational from the grant):
  - mem_write_enable = grant & address_in_range.
  - mem_address and mem_input_data come from the granted requester.
  - The write lands on the same clock edge as the handshake.
  - Address >= mem_depth: the handshake still completes, the write is suppressed, and wr_err sets. wr_err clears only on reset.
- Read FSM, states IDLE and READ:
  - IDLE: on rd_start, capture rd_base, set rcnt=0, go to READ. rd_busy=1 from the next cycle.
  - READ: mem_read_address = rd_base+rcnt; rcnt increments every cycle with no backpressure. After issuing W-1, go to IDLE.
  - mem_read_address holds its last value in IDLE.
  - rd_data is registered from mem_output: word k appears one cycle after address k is issued, with rd_data_valid=1.
  - rd_last=1 with word W-1. rd_busy deasserts in the same cycle the last word is valid.
  - rd_start while busy is ignored. rd_start in the cycle rd_last is high is accepted (back-to-back bursts).
- Read/write hazard: a read of an address written in the same cycle returns the old contents. Write-to-read ordering is the sequencer client's responsibility.
- Address arithmetic is 32-bit with wrap; wrapped addresses fall into the range check.

Test Plan:
- Reset mid-burst: rd_start with rd_base=10, then rst_n low for 1 cycle after the first address. Required: all outputs 0, FSMs IDLE, no further rd_data_valid.
- A-only vector: wa_start with wa_base=4, wa_valid held high, data 0xA0/0xA1. Required: writes hit addresses 4 and 5 on consecutive edges, and wa_done pulses once on the cycle after.
- Contention: A ACTIVE (base 0) and wb_valid with wb_addr=100 held high together. Required: grants are A, B, A (alternating), A completes 2 words, B lands exactly once per grant, and wa_ready/wb_ready are never both high.
- Out of range: wb_addr=2001 with wb_valid. Required: wb_ready=1, mem_write_enable=0, wr_err=1 and stays set until reset.
- Read burst after A writes: rd_base=4. Required: rd_data = 0xA0 then 0xA1 on cycles 1 and 2 after start, rd_last on the second, rd_busy low afterwards.
- Back-to-back reads: rd_start asserted with rd_last. Required: continuous rd_data_valid for 4 cycles; a rd_start issued mid-burst is ignored.

Source files
------------

// File: rtl/ap_mem_scheduler_if.sv
// ============================================================================
//  Module      : ap_mem_scheduler_if
//  Description : Bundle of requester, read-sequencer and memory-pin signals
//                shared between the AP vector memory scheduler and its
//                surroundings (CG datapath on one side, memory on the other).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ap_mem_scheduler_if #(
   parameter int DATA_WIDTH = 512
);
   // Requester A: matrix-vector unit, sequential vector writes
   logic                  wa_start;
   logic [31:0]           wa_base;
   logic                  wa_valid;
   logic [DATA_WIDTH-1:0] wa_data;
   logic                  wa_ready;
   logic                  wa_done;
   // Requester B: loader/host, single random-address writes
   logic                  wb_valid;
   logic [31:0]           wb_addr;
   logic [DATA_WIDTH-1:0] wb_data;
   logic                  wb_ready;
   // Read sequencer towards the dot-product unit
   logic                  rd_start;
   logic [31:0]           rd_base;
   logic                  rd_busy;
   logic                  rd_data_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_last;
   logic                  wr_err;
   // Memory pins
   logic                  mem_write_enable;
   logic [31:0]           mem_address;
   logic [DATA_WIDTH-1:0] mem_input_data;
   logic [31:0]           mem_read_address;
   logic [DATA_WIDTH-1:0] mem_output;

   // Environment side: requesters, read client and the memory itself
   modport master (
      output wa_start, wa_base, wa_valid, wa_data,
      input  wa_ready, wa_done,
      output wb_valid, wb_addr, wb_data,
      input  wb_ready,
      output rd_start, rd_base,
      input  rd_busy, rd_data_valid, rd_data, rd_last, wr_err,
      input  mem_write_enable, mem_address, mem_input_data, mem_read_address,
      output mem_output
   );

   // Scheduler side
   modport slave (
      input  wa_start, wa_base, wa_valid, wa_data,
      output wa_ready, wa_done,
      input  wb_valid, wb_addr, wb_data,
      output wb_ready,
      input  rd_start, rd_base,
      output rd_busy, rd_data_valid, rd_data, rd_last, wr_err,
      output mem_write_enable, mem_address, mem_input_data, mem_read_address,
      input  mem_output
   );
endinterface

`default_nettype wire

// File: rtl/ap_mem_scheduler.sv
// ============================================================================
//  Module      : ap_mem_scheduler
//  Description : Shares the wide AP vector memory between a sequential vector
//                writer (A), a random single-word writer (B) and a burst
//                reader with a registered one-cycle-latency output.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ap_mem_scheduler #(
   parameter int ELEMENT_WIDTH                   = 64,
   parameter int NO_OF_UNITS                     = 8,
   parameter int NUMBER_OF_EQUATIONS_PER_CLUSTER = 9,
   parameter int MEM_DEPTH                       = 2001
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   ap_mem_scheduler_if.slave  bus
);

   localparam int          c_DW     = ELEMENT_WIDTH * NO_OF_UNITS;
   localparam int          c_W      = (NUMBER_OF_EQUATIONS_PER_CLUSTER + NO_OF_UNITS - 1) / NO_OF_UNITS;
   localparam logic [31:0] c_LAST   = 32'(c_W - 1);
   localparam logic [31:0] c_DEPTH  = 32'(MEM_DEPTH);
   // A one-word vector never needs the READ state: the start cycle issues it all
   localparam logic        c_SINGLE = (c_W == 1);

   localparam logic [0:0] S_WA_IDLE   = 1'b0;
   localparam logic [0:0] S_WA_ACTIVE = 1'b1;
   localparam logic [0:0] S_RD_IDLE   = 1'b0;
   localparam logic [0:0] S_RD_READ   = 1'b1;

   // ---------------------------------------------------------------- write side
   logic [0:0]      r_wa_state;
   logic [0:0]      w_wa_state_nxt;
   logic [31:0]     r_wa_base;
   logic [31:0]     r_wcnt;
   logic            r_wa_done;
   logic            r_last_b;
   logic            r_wr_err;
   logic            w_wa_active;
   logic            w_cand_a;
   logic            w_cand_b;
   logic            w_grant_a;
   logic            w_grant_b;
   logic [31:0]     w_waddr;
   logic            w_in_range;

   // Write FSM A state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_wa_state <= S_WA_IDLE;
      else        r_wa_state <= w_wa_state_nxt;
   end

   // Write FSM A next state: leave ACTIVE on acceptance of the last word
   always_comb begin
      w_wa_state_nxt = r_wa_state;
      case (r_wa_state)
         S_WA_IDLE:   if (bus.wa_start) w_wa_state_nxt = S_WA_ACTIVE;
         S_WA_ACTIVE: if (w_grant_a && (r_wcnt == c_LAST)) w_wa_state_nxt = S_WA_IDLE;
         default:     w_wa_state_nxt = S_WA_IDLE;
      endcase
   end

   // Write FSM A outputs, round-robin grant and memory write drive
   always_comb begin
      w_wa_active = (r_wa_state == S_WA_ACTIVE);
      w_cand_a    = w_wa_active & bus.wa_valid;
      w_cand_b    = bus.wb_valid;
      // On contention the requester that was not granted last wins
      w_grant_a   = w_cand_a & (~w_cand_b | r_last_b);
      w_grant_b   = w_cand_b & ~w_grant_a;
      w_waddr     = '0;
      if (w_grant_a)      w_waddr = r_wa_base + r_wcnt;
      else if (w_grant_b) w_waddr = bus.wb_addr;
      w_in_range  = (w_waddr < c_DEPTH);
   end

   // A base/counter, done pulse, round-robin pointer and sticky range error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wa_base <= '0;
         r_wcnt    <= '0;
         r_wa_done <= 1'b0;
         r_last_b  <= 1'b1;
         r_wr_err  <= 1'b0;
      end else begin
         if (!w_wa_active && bus.wa_start) begin
            r_wa_base <= bus.wa_base;
            r_wcnt    <= '0;
         end else if (w_grant_a) begin
            r_wcnt    <= r_wcnt + 32'd1;
         end
         r_wa_done <= w_grant_a & (r_wcnt == c_LAST);
         if (w_grant_a)      r_last_b <= 1'b0;
         else if (w_grant_b) r_last_b <= 1'b1;
         if ((w_grant_a | w_grant_b) & ~w_in_range) r_wr_err <= 1'b1;
      end
   end

   assign bus.wa_ready         = w_grant_a;
   assign bus.wb_ready         = w_grant_b;
   assign bus.wa_done          = r_wa_done;
   assign bus.wr_err           = r_wr_err;
   assign bus.mem_write_enable = (w_grant_a | w_grant_b) & w_in_range;
   assign bus.mem_address      = w_waddr;
   assign bus.mem_input_data   = w_grant_a ? bus.wa_data :
                                 (w_grant_b ? bus.wb_data : '0);

   // ----------------------------------------------------------------- read side
   logic [0:0]      r_rd_state;
   logic [0:0]      w_rd_state_nxt;
   logic [31:0]     r_rd_base;
   logic [31:0]     r_rcnt;
   logic [31:0]     r_raddr;
   logic            r_rd_valid;
   logic            r_rd_last;
   logic [c_DW-1:0] r_rd_data;
   logic            w_rd_idle;
   logic            w_rd_issue;
   logic            w_rd_is_last;
   logic [31:0]     w_rd_addr;

   // Read FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rd_state <= S_RD_IDLE;
      else        r_rd_state <= w_rd_state_nxt;
   end

   // Read FSM next state: word 0 goes out in the start cycle, READ issues the rest
   always_comb begin
      w_rd_state_nxt = r_rd_state;
      case (r_rd_state)
         S_RD_IDLE: if (bus.rd_start && !c_SINGLE) w_rd_state_nxt = S_RD_READ;
         S_RD_READ: if (r_rcnt == c_LAST) w_rd_state_nxt = S_RD_IDLE;
         default:   w_rd_state_nxt = S_RD_IDLE;
      endcase
   end

   // Read FSM outputs: which address goes out this cycle, and whether it is the last
   always_comb begin
      w_rd_idle    = (r_rd_state == S_RD_IDLE);
      w_rd_issue   = (w_rd_idle & bus.rd_start) | ~w_rd_idle;
      w_rd_is_last = w_rd_idle ? c_SINGLE : (r_rcnt == c_LAST);
      w_rd_addr    = r_raddr;
      if (w_rd_idle && bus.rd_start) w_rd_addr = bus.rd_base;
      else if (!w_rd_idle)           w_rd_addr = r_rd_base + r_rcnt;
   end

   // Read base/counter, held read address and the registered output word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_base  <= '0;
         r_rcnt     <= '0;
         r_raddr    <= '0;
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         if (w_rd_idle && bus.rd_start) begin
            r_rd_base <= bus.rd_base;
            r_rcnt    <= 32'd1;
         end else if (!w_rd_idle) begin
            r_rcnt    <= r_rcnt + 32'd1;
         end
         r_raddr    <= w_rd_addr;
         r_rd_valid <= w_rd_issue;
         r_rd_last  <= w_rd_issue & w_rd_is_last;
         if (w_rd_issue) r_rd_data <= bus.mem_output;
      end
   end

   assign bus.mem_read_address = w_rd_addr;
   assign bus.rd_busy          = ~w_rd_idle;
   assign bus.rd_data_valid    = r_rd_valid;
   assign bus.rd_last          = r_rd_last;
   assign bus.rd_data          = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_ap_mem_scheduler.sv
// ============================================================================
//  Module      : tb_ap_mem_scheduler
//  Description : Directed self-checking bench for ap_mem_scheduler with a
//                behavioural memory and a read-data scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ap_mem_scheduler;

   localparam int DW    = 512;
   localparam int DEPTH = 2001;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } rd_exp_t;

   logic    clk   = 1'b0;
   logic    rst_n = 1'b0;
   int      total = 0;
   int      bad   = 0;
   rd_exp_t rq[$];
   rd_exp_t r_exp;

   logic [DW-1:0] mem [0:DEPTH-1];

   always #5 clk = ~clk;

   ap_mem_scheduler_if #(.DATA_WIDTH(DW)) bus ();

   ap_mem_scheduler #(
      .ELEMENT_WIDTH                   (64),
      .NO_OF_UNITS                     (8),
      .NUMBER_OF_EQUATIONS_PER_CLUSTER (9),
      .MEM_DEPTH                       (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural memory: synchronous write, combinational read
   always @(posedge clk) begin
      if (bus.mem_write_enable) mem[bus.mem_address[10:0]] <= bus.mem_input_data;
   end
   assign bus.mem_output = (bus.mem_read_address < 32'(DEPTH)) ? mem[bus.mem_read_address[10:0]] : '0;

   function automatic logic [DW-1:0] pat(input logic [31:0] v);
      return {16{v}};
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      check(tag, {{(DW-1){1'b0}}, obs}, {{(DW-1){1'b0}}, exp});
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check(tag, {{(DW-32){1'b0}}, obs}, {{(DW-32){1'b0}}, exp});
   endtask

   task automatic push(input logic [DW-1:0] d, input logic l);
      rd_exp_t e;
      e.data = d;
      e.last = l;
      rq.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every valid read word must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && bus.rd_data_valid) begin
         if (rq.size() == 0) begin
            check1("rd_unexpected", bus.rd_data_valid, 1'b0);
         end else begin
            r_exp = rq.pop_front();
            check("rd_data", bus.rd_data, r_exp.data);
            check1("rd_last", bus.rd_last, r_exp.last);
         end
      end
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      bus.wa_start = 1'b0; bus.wa_base = '0; bus.wa_valid = 1'b0; bus.wa_data = '0;
      bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
      bus.rd_start = 1'b0; bus.rd_base = '0;

      // ---- reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check1("rst_wa_ready", bus.wa_ready, 1'b0);
      check1("rst_wa_done", bus.wa_done, 1'b0);
      check1("rst_wb_ready", bus.wb_ready, 1'b0);
      check1("rst_rd_busy", bus.rd_busy, 1'b0);
      check1("rst_rd_valid", bus.rd_data_valid, 1'b0);
      check("rst_rd_data", bus.rd_data, '0);
      check1("rst_rd_last", bus.rd_last, 1'b0);
      check1("rst_wr_err", bus.wr_err, 1'b0);
      check1("rst_mem_we", bus.mem_write_enable, 1'b0);
      check32("rst_mem_addr", bus.mem_address, 32'd0);
      check("rst_mem_din", bus.mem_input_data, '0);
      check32("rst_mem_raddr", bus.mem_read_address, 32'd0);

      // ---- reset in the middle of a read burst
      tick(); rst_n = 1'b1;
      tick(); bus.rd_start = 1'b1; bus.rd_base = 32'd10;
      @(negedge clk);
      check32("mid_raddr0", bus.mem_read_address, 32'd10);
      check1("mid_busy0", bus.rd_busy, 1'b0);
      tick(); bus.rd_start = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      check1("mid_rst_busy", bus.rd_busy, 1'b0);
      check1("mid_rst_valid", bus.rd_data_valid, 1'b0);
      check32("mid_rst_raddr", bus.mem_read_address, 32'd0);
      check("mid_rst_rdata", bus.rd_data, '0);
      tick(); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         check1("mid_after_valid", bus.rd_data_valid, 1'b0);
         check1("mid_after_busy", bus.rd_busy, 1'b0);
         check32("mid_after_raddr", bus.mem_read_address, 32'd0);
      end

      // ---- A-only vector at base 4; valid already high while still IDLE
      tick(); bus.wa_start = 1'b1; bus.wa_base = 32'd4; bus.wa_valid = 1'b1; bus.wa_data = pat(32'hA0);
      @(negedge clk);
      check1("a_idle_ready", bus.wa_ready, 1'b0);
      check1("a_idle_we", bus.mem_write_enable, 1'b0);
      tick(); bus.wa_start = 1'b0;
      @(negedge clk);
      check1("a_w0_ready", bus.wa_ready, 1'b1);
      check1("a_w0_we", bus.mem_write_enable, 1'b1);
      check32("a_w0_addr", bus.mem_address, 32'd4);
      check("a_w0_data", bus.mem_input_data, pat(32'hA0));
      check1("a_w0_done", bus.wa_done, 1'b0);
      tick(); bus.wa_data = pat(32'hA1);
      @(negedge clk);
      check1("a_w1_ready", bus.wa_ready, 1'b1);
      check32("a_w1_addr", bus.mem_address, 32'd5);
      check("a_w1_data", bus.mem_input_data, pat(32'hA1));
      check1("a_w1_done", bus.wa_done, 1'b0);
      tick(); bus.wa_valid = 1'b0;
      @(negedge clk);
      check1("a_done_pulse", bus.wa_done, 1'b1);
      check1("a_done_ready", bus.wa_ready, 1'b0);
      check1("a_done_we", bus.mem_write_enable, 1'b0);
      tick();
      @(negedge clk);
      check1("a_done_clear", bus.wa_done, 1'b0);

      // ---- single B write so that B is the last grant before contention
      tick(); bus.wb_valid = 1'b1; bus.wb_addr = 32'd50; bus.wb_data = pat(32'h55);
      @(negedge clk);
      check1("b50_ready", bus.wb_ready, 1'b1);
      check1("b50_we", bus.mem_write_enable, 1'b1);
      check32("b50_addr", bus.mem_address, 32'd50);

      // ---- contention: A base 0 vs B at 100
      tick(); bus.wb_valid = 1'b0; bus.wa_start = 1'b1; bus.wa_base = 32'd0;
      @(negedge clk);
      check1("ct_start_ready", bus.wb_ready | bus.wa_ready, 1'b0);
      tick(); bus.wa_start = 1'b0; bus.wa_valid = 1'b1; bus.wa_data = pat(32'hD0);
      bus.wb_valid = 1'b1; bus.wb_addr = 32'd100; bus.wb_data = pat(32'hB0);
      @(negedge clk);
      check1("ct1_a", bus.wa_ready, 1'b1);
      check1("ct1_both", bus.wa_ready & bus.wb_ready, 1'b0);
      check32("ct1_addr", bus.mem_address, 32'd0);
      check("ct1_data", bus.mem_input_data, pat(32'hD0));
      tick(); bus.wa_data = pat(32'hD1);
      @(negedge clk);
      check1("ct2_b", bus.wb_ready, 1'b1);
      check1("ct2_both", bus.wa_ready & bus.wb_ready, 1'b0);
      check1("ct2_we", bus.mem_write_enable, 1'b1);
      check32("ct2_addr", bus.mem_address, 32'd100);
      check("ct2_data", bus.mem_input_data, pat(32'hB0));
      tick();
      @(negedge clk);
      check1("ct3_a", bus.wa_ready, 1'b1);
      check1("ct3_both", bus.wa_ready & bus.wb_ready, 1'b0);
      check32("ct3_addr", bus.mem_address, 32'd1);
      check("ct3_data", bus.mem_input_data, pat(32'hD1));
      tick(); bus.wa_valid = 1'b0;
      @(negedge clk);
      check1("ct4_b", bus.wb_ready, 1'b1);
      check1("ct4_a", bus.wa_ready, 1'b0);
      check32("ct4_addr", bus.mem_address, 32'd100);
      check1("ct4_done", bus.wa_done, 1'b1);

      // ---- out-of-range B write
      tick(); bus.wb_addr = 32'd2001; bus.wb_data = pat(32'hFF);
      @(negedge clk);
      check1("oor_ready", bus.wb_ready, 1'b1);
      check1("oor_we", bus.mem_write_enable, 1'b0);
      check1("oor_err_before", bus.wr_err, 1'b0);
      tick(); bus.wb_valid = 1'b0;
      @(negedge clk);
      check1("oor_err_set", bus.wr_err, 1'b1);

      // ---- read burst from base 4
      tick(); bus.rd_start = 1'b1; bus.rd_base = 32'd4;
      push(pat(32'hA0), 1'b0);
      push(pat(32'hA1), 1'b1);
      @(negedge clk);
      check32("rd_raddr0", bus.mem_read_address, 32'd4);
      check1("rd_busy0", bus.rd_busy, 1'b0);
      check1("rd_valid0", bus.rd_data_valid, 1'b0);
      tick(); bus.rd_start = 1'b0;
      @(negedge clk);
      check1("rd_busy1", bus.rd_busy, 1'b1);
      check1("rd_valid1", bus.rd_data_valid, 1'b1);
      check32("rd_raddr1", bus.mem_read_address, 32'd5);
      tick();
      @(negedge clk);
      check1("rd_busy2", bus.rd_busy, 1'b0);
      check1("rd_valid2", bus.rd_data_valid, 1'b1);
      tick();
      @(negedge clk);
      check1("rd_valid3", bus.rd_data_valid, 1'b0);
      check32("rd_raddr_hold", bus.mem_read_address, 32'd5);
      check1("oor_err_sticky", bus.wr_err, 1'b1);

      // ---- back-to-back bursts, with an ignored mid-burst start
      tick(); bus.rd_start = 1'b1; bus.rd_base = 32'd0;
      push(pat(32'hD0), 1'b0);
      push(pat(32'hD1), 1'b1);
      @(negedge clk);
      check32("bb_raddr0", bus.mem_read_address, 32'd0);
      tick(); bus.rd_base = 32'd50;
      @(negedge clk);
      check1("bb_valid1", bus.rd_data_valid, 1'b1);
      check32("bb_raddr1", bus.mem_read_address, 32'd1);
      tick(); bus.rd_base = 32'd100;
      push(pat(32'hB0), 1'b0);
      push('0, 1'b1);
      @(negedge clk);
      check1("bb_valid2", bus.rd_data_valid, 1'b1);
      check1("bb_last2", bus.rd_last, 1'b1);
      check1("bb_busy2", bus.rd_busy, 1'b0);
      check32("bb_raddr2", bus.mem_read_address, 32'd100);
      tick(); bus.rd_start = 1'b0;
      @(negedge clk);
      check1("bb_valid3", bus.rd_data_valid, 1'b1);
      check32("bb_raddr3", bus.mem_read_address, 32'd101);
      tick();
      @(negedge clk);
      check1("bb_valid4", bus.rd_data_valid, 1'b1);
      check1("bb_busy4", bus.rd_busy, 1'b0);
      tick();
      @(negedge clk);
      check1("bb_valid5", bus.rd_data_valid, 1'b0);
      check32("rq_empty", 32'(rq.size()), 32'd0);

      // ---- only reset clears the error flag
      tick(); rst_n = 1'b0;
      @(negedge clk);
      check1("err_reset", bus.wr_err, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
